// File: rtl/rotation_undo.sv
// ---------------------------------------------------------------------------
// rotation_undo
//
// Iterative inverse of a STAGES-deep chain of conditional add/subtract
// rotation stages. A job carries the forward chain output (Din), the chain's
// stage-0 delta (Base) and the per-stage execute/direction decisions taken by
// the forward stages. The block replays those decisions from the last stage
// down to stage 0, one stage per clock, and presents the recovered chain
// input on Dout.
//
// Ports
//   clock      in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a job is offered on Din/Base/exec_rott/direction
//   in_ready   out  the block can accept a job
//   Din        in   forward-chain output to undo (signed)
//   Base       in   stage-0 delta (signed); stage k used Base >>> k
//   exec_rott  in   bit k = 1: forward stage k applied its delta
//   direction  in   bit k = 0: forward stage k added; 1: it subtracted
//   out_valid  out  Dout holds a finished result
//   out_ready  in   consumer takes the result
//   Dout       out  recovered chain input (signed)
//   busy       out  job in progress or result waiting
//
// All outputs come straight from flops; nothing combinational reaches them
// from the inputs.
// ---------------------------------------------------------------------------
module rotation_undo #(
  parameter int DSIZE  = 16,
  parameter int STAGES = 8
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DSIZE-1:0] Din,
  input  logic signed [DSIZE-1:0] Base,
  input  logic [STAGES-1:0]       exec_rott,
  input  logic [STAGES-1:0]       direction,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DSIZE-1:0] Dout,
  output logic                    busy
);

  // Stage counter width: $clog2(STAGES), but never narrower than one bit.
  localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;
  // The step table is padded to a power of two so that every counter value
  // indexes a defined entry even when STAGES is not a power of two.
  localparam int NTAB = 1 << KW;
  localparam logic [KW-1:0] K_LAST = KW'(STAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ------------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------------
  state_t                    r_state;
  logic signed [DSIZE-1:0]   r_acc;
  logic signed [DSIZE-1:0]   r_base;
  logic [STAGES-1:0]         r_ex;
  logic [STAGES-1:0]         r_dr;
  logic [KW-1:0]             r_k;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic signed [DSIZE-1:0]   r_dout;
  logic                      r_busy;

  // Next-state values produced by the combinational processes.
  state_t                    w_state_next;
  logic signed [DSIZE-1:0]   w_acc_next;
  logic signed [DSIZE-1:0]   w_base_next;
  logic [STAGES-1:0]         w_ex_next;
  logic [STAGES-1:0]         w_dr_next;
  logic [KW-1:0]             w_k_next;
  logic                      w_in_ready_next;
  logic                      w_out_valid_next;
  logic signed [DSIZE-1:0]   w_dout_next;
  logic                      w_busy_next;

  logic                      w_accept;
  logic                      w_last_stage;
  logic signed [DSIZE-1:0]   w_step_tab [NTAB];
  logic signed [DSIZE-1:0]   w_step;
  logic signed [DSIZE-1:0]   w_acc_upd;

  // A job is taken only from IDLE, and only once in_ready is already high,
  // so the cycle right after reset release can never accept.
  assign w_accept     = (r_state == S_IDLE) && in_valid && r_in_ready;
  assign w_last_stage = (r_k == '0);

  // ------------------------------------------------------------------------
  // Per-stage correction term. Undoing a forward add means subtracting the
  // stage delta and vice versa, so each entry already carries the inverse
  // sign. Skipped stages contribute zero. Adding the negated delta is
  // identical to subtracting it modulo 2^DSIZE, so wrapped forward results
  // invert exactly.
  // ------------------------------------------------------------------------
  for (genvar gi = 0; gi < NTAB; gi++) begin : g_step
    if (gi < STAGES) begin : g_live
      logic signed [DSIZE-1:0] w_delta;
      assign w_delta = r_base >>> gi;
      assign w_step_tab[gi] = !r_ex[gi] ? '0 :
                              (r_dr[gi] ? w_delta : -w_delta);
    end else begin : g_pad
      assign w_step_tab[gi] = '0;
    end
  end

  assign w_step    = w_step_tab[r_k];
  assign w_acc_upd = r_acc + w_step;

  // ------------------------------------------------------------------------
  // Process 1: state and datapath registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_base      <= '0;
      r_ex        <= '0;
      r_dr        <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_base      <= w_base_next;
      r_ex        <= w_ex_next;
      r_dr        <= w_dr_next;
      r_k         <= w_k_next;
      r_in_ready  <= w_in_ready_next;
      r_out_valid <= w_out_valid_next;
      r_dout      <= w_dout_next;
      r_busy      <= w_busy_next;
    end
  end

  // ------------------------------------------------------------------------
  // Process 2: next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept)     w_state_next = S_RUN;
      S_RUN:  if (w_last_stage) w_state_next = S_DONE;
      S_DONE: if (out_ready)    w_state_next = S_IDLE;
      default:                  w_state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Process 3: next values of the datapath and registered outputs
  // ------------------------------------------------------------------------
  always_comb begin
    w_acc_next       = r_acc;
    w_base_next      = r_base;
    w_ex_next        = r_ex;
    w_dr_next        = r_dr;
    w_k_next         = r_k;
    w_in_ready_next  = r_in_ready;
    w_out_valid_next = r_out_valid;
    w_dout_next      = r_dout;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_next      = Din;
          w_base_next     = Base;
          w_ex_next       = exec_rott;
          w_dr_next       = direction;
          w_k_next        = K_LAST;
          w_in_ready_next = 1'b0;
        end else begin
          // Raises in_ready on the first edge after reset release.
          w_in_ready_next = 1'b1;
        end
      end

      S_RUN: begin
        w_acc_next = w_acc_upd;
        if (w_last_stage) begin
          w_out_valid_next = 1'b1;
          w_dout_next      = w_acc_upd;
        end else begin
          w_k_next = r_k - KW'(1);
        end
      end

      S_DONE: begin
        // Dout is left untouched; it keeps the last result until the next
        // job completes.
        if (out_ready) begin
          w_out_valid_next = 1'b0;
          w_in_ready_next  = 1'b1;
        end
      end

      default: begin
        w_out_valid_next = 1'b0;
        w_in_ready_next  = 1'b0;
      end
    endcase
  end

  // busy tracks the state register itself, so it is computed from the next
  // state to stay aligned with it.
  assign w_busy_next = (w_state_next != S_IDLE);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Dout      = r_dout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rotation_undo.sv
module tb_rotation_undo;

  localparam int DSIZE  = 16;
  localparam int STAGES = 4;

  logic                    clock = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [DSIZE-1:0] din;
  logic signed [DSIZE-1:0] base;
  logic [STAGES-1:0]       exec_rott;
  logic [STAGES-1:0]       direction;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [DSIZE-1:0] dout;
  logic                    busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected Dout values, one per accepted job.
  logic [DSIZE-1:0] sb [$];

  rotation_undo #(.DSIZE(DSIZE), .STAGES(STAGES)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Din       (din),
    .Base      (base),
    .exec_rott (exec_rott),
    .direction (direction),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Dout      (dout),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DSIZE-1:0] obs,
                       input logic [DSIZE-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  // Reference inverse: walk stages STAGES-1..0 undoing each decision.
  function automatic logic [DSIZE-1:0] undo_model(
      input logic signed [DSIZE-1:0] x, input logic signed [DSIZE-1:0] b,
      input logic [STAGES-1:0] ex, input logic [STAGES-1:0] dr);
    logic signed [DSIZE-1:0] a;
    a = x;
    for (int k = STAGES - 1; k >= 0; k--)
      if (ex[k]) a = dr[k] ? a + (b >>> k) : a - (b >>> k);
    return a;
  endfunction

  // Reference forward chain: stage 0 first, add when direction bit is 0.
  function automatic logic [DSIZE-1:0] forward_model(
      input logic signed [DSIZE-1:0] x, input logic signed [DSIZE-1:0] b,
      input logic [STAGES-1:0] ex, input logic [STAGES-1:0] dr);
    logic signed [DSIZE-1:0] a;
    a = x;
    for (int k = 0; k < STAGES; k++)
      if (ex[k]) a = dr[k] ? a - (b >>> k) : a + (b >>> k);
    return a;
  endfunction

  // Offer a job and wait for its acceptance edge; leaves time at edge+1.
  task automatic offer(input logic signed [DSIZE-1:0] d,
                       input logic signed [DSIZE-1:0] b,
                       input logic [STAGES-1:0] ex, input logic [STAGES-1:0] dr,
                       input logic [DSIZE-1:0] exp);
    int n;
    din = d; base = b; exec_rott = ex; direction = dr; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    sb.push_back(exp);
    $display("offer   Din=%04h Base=%04h ex=%b dr=%b expect=%04h", d, b, ex, dr, exp);
  endtask

  // Count exactly STAGES edges after acceptance, then compare with scoreboard.
  task automatic expect_result(input string tag);
    logic [DSIZE-1:0] exp;
    for (int i = 1; i <= STAGES; i++) begin
      @(posedge clock); #1;
      if (i < STAGES) check({tag, "_early_valid"}, out_valid, 0);
      else            check({tag, "_latency"}, out_valid, 1);
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      exp = sb.pop_front();
      check(tag, dout, exp);
      $display("result  %s Dout=%04h expect=%04h", tag, dout, exp);
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
    check({tag, "_idle"}, busy, 0);
  endtask

  logic [DSIZE-1:0] held;
  logic [DSIZE-1:0] exp_b;
  logic             seen_valid;

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    // A job is offered throughout reset and the first cycle; it must be ignored.
    in_valid = 1'b1; din = 16'sh0777; base = 16'sd16;
    exec_rott = 4'b1111; direction = 4'b0000;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clock);
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;
    check("first_edge_in_ready", in_ready, 1);
    check("first_edge_no_accept", busy, 0);
    in_valid = 1'b0;

    // Baseline undo: 100 - 16 - 8 - 4 - 2.
    offer(16'sd100, 16'sd16, 4'b1111, 4'b0000, 16'd70);
    check("accept_busy", busy, 1);
    check("accept_ready_low", in_ready, 0);
    expect_result("baseline");
    handshake("baseline");

    // Mixed decisions: +2 -4 +8 -16.
    offer(16'sd0, 16'sd16, 4'b1111, 4'b1010, 16'hFFF6);
    expect_result("mixed");
    handshake("mixed");

    // No-op job.
    offer(16'sh1234, 16'sd16, 4'b0000, 4'b0000, 16'h1234);
    expect_result("noop");
    handshake("noop");

    // Negative base: -16 >>> 3 = -2, undoing the add gives +2.
    offer(16'sd0, -16'sd16, 4'b1000, 4'b0000, 16'd2);
    expect_result("neg_base");
    handshake("neg_base");

    // Wrap-around, then confirm the forward chain maps the result back.
    offer(16'sh7FFF, 16'sd16, 4'b1111, 4'b1111, 16'h801D);
    expect_result("wrap");
    check("wrap_forward", forward_model(dout, 16'sd16, 4'b1111, 4'b1111), 16'h7FFF);
    handshake("wrap");

    // Backpressure: result held for 10 cycles while a new job waits.
    offer(16'sh0100, 16'sd40, 4'b0101, 4'b0001,
          undo_model(16'sh0100, 16'sd40, 4'b0101, 4'b0001));
    expect_result("bp_first");
    held = dout;
    din = 16'sh0500; base = -16'sd100; exec_rott = 4'b0110; direction = 4'b0100;
    exp_b = undo_model(16'sh0500, -16'sd100, 4'b0110, 4'b0100);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("bp_valid_hold", out_valid, 1);
      check("bp_dout_hold", dout, held);
      check("bp_ready_low", in_ready, 0);
      check("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    sb.push_back(exp_b);
    $display("offer   Din=0500 (queued job) expect=%04h", exp_b);
    check("bp_next_accepted", busy, 1);
    expect_result("bp_second");
    handshake("bp_second");

    // Reset two cycles after acceptance aborts the job.
    offer(16'sh2222, 16'sd16, 4'b1111, 4'b0000,
          undo_model(16'sh2222, 16'sd16, 4'b1111, 4'b0000));
    repeat (2) begin @(posedge clock); #1; end
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_out_valid", out_valid, 0);
    check("abort_dout", dout, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;
    check("abort_ready_back", in_ready, 1);
    seen_valid = 1'b0;
    for (int i = 0; i < STAGES + 4; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_pulse", seen_valid, 0);

    // Recovery job after the abort.
    offer(16'sd100, 16'sd16, 4'b1111, 4'b0000, 16'd70);
    expect_result("post_reset");
    handshake("post_reset");

    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
